instr_fetch_ctrl: RTL and testbench
===================================

# instr_fetch_ctrl

Fetch sequencer for the MIPS instruction memory. Owns the program counter and drives `instr_addr` of the combinational `instruction_memory`. Registers each returned word, with its PC, into a one-entry output stage handed to decode over a valid/ready handshake. Supports start, stall via backpressure, PC redirect (branch/jump), and end-of-program halt.

## Interface
- `ADDR_W`, 32: width of PC and `instr_addr`; word-indexed, increment 1.
- `DATA_W`, 32: instruction width.
- `DEPTH`, 16: number of instruction words; valid PCs are 0..DEPTH-1.
- `RESET_PC`, 0: PC loaded at reset and on `start`.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begin fetching from `RESET_PC`.
- `instr_addr`  out  ADDR_W  address to instruction memory; equals current PC.
- `instr`  in  DATA_W  word from instruction memory, combinational from `instr_addr`.
- `redirect_valid`  in  1  load `redirect_pc` into PC and flush the output stage.
- `redirect_pc`  in  ADDR_W  redirect target.
- `if_valid`  out  1  output stage holds an instruction.
- `if_ready`  in  1  decode accepts the output stage this cycle.
- `if_instr`  out  DATA_W  fetched instruction.
- `if_pc`  out  ADDR_W  PC of `if_instr`.
- `busy`  out  1  state is FETCH or DRAIN.
- `halted`  out  1  state is HALT.
- `fault`  out  1  sticky; set by an out-of-range redirect, cleared by `start`.

## Operation
- States:
  - IDLE (reset).
  - FETCH.
  - DRAIN: last word captured; waiting for decode to take it.
  - HALT.
- IDLE -> FETCH on `start`. PC = `RESET_PC`, `fault` = 0.
- FETCH, capture rule:
  - Capture fires when `!if_valid || if_ready`.
  - On capture: `if_instr` <= `instr`, `if_pc` <= PC, `if_valid` <= 1, PC <= PC+1.
  - Otherwise PC and the output stage hold (stall).
- FETCH, last address: capture at PC = DEPTH-1 goes to DRAIN; PC holds at DEPTH-1.
- DRAIN -> HALT when `if_valid && if_ready`. In DRAIN, `if_valid` <= 0 on acceptance.
- HALT -> FETCH on `start`: PC = `RESET_PC`, `fault` cleared.
- Acceptance without capture clears `if_valid`.
- Redirect, valid in FETCH or DRAIN:
  - Highest priority over capture and over the DEPTH-1 transition.
  - Output stage flushed: `if_valid` <= 0 next cycle, regardless of `if_ready`.
  - If `redirect_pc` < DEPTH: PC <= `redirect_pc`, state -> FETCH.
  - If `redirect_pc` >= DEPTH: `fault` <= 1, state -> HALT.
- Redirect in IDLE or HALT is ignored.
- `start` in FETCH or DRAIN is ignored.
- PC arithmetic: unsigned ADDR_W; never exceeds DEPTH-1 in FETCH.

## Timing
- Reset values: `instr_addr` = `RESET_PC`, `if_valid` = 0, `if_instr` = 0, `if_pc` = 0, `busy` = 0, `halted` = 0, `fault` = 0, state IDLE.
- `rst_n` low mid-operation returns all of the above immediately; any in-flight `if_valid` is dropped.
- Latency: address A driven in cycle N gives `if_valid`/`if_instr` = mem[A] at cycle N+1.
- Throughput: one instruction per cycle while `if_ready` = 1.
- `if_instr`/`if_pc` are stable while `if_valid && !if_ready`.
- `start` accepted at cycle N: `busy` = 1 and `instr_addr` = `RESET_PC` at N+1; first `if_valid` at N+2.
- Redirect at cycle N: `instr_addr` = target at N+1; `if_valid` = 0 at N+1; target word valid at N+2.
- `busy`, `halted`, `fault` are registered state decodes.

## Configuration
- `IFETCH_WRAP_EN` defined:
  - Capture at DEPTH-1 sets PC <= 0 and stays in FETCH.
  - DRAIN is never entered; HALT is reached only via a faulting redirect.
- Not defined: the halt behaviour described above.

## Structure
- Shared package `mips_pkg` holds:
  - Fetch state enum (IDLE, FETCH, DRAIN, HALT).
  - `IMEM_DEPTH` = 16.
  - Word width constants.
- One sub-module, `ifetch_out_reg`: the valid/ready output stage (capture enable, flush, data/PC registers).
- The FSM and PC stay in `instr_fetch_ctrl`.

## Test plan
- Reset then `start`, `if_ready` = 1, memory preloaded with words i -> `if_pc` 0..15 on consecutive cycles, each `if_instr` = mem[i]; DRAIN, then `halted` = 1 one cycle after PC 15 is accepted.
- `if_ready` low for 3 cycles while `if_pc` = 4 -> `if_pc`/`if_instr` held, `instr_addr` = 5 held; resumes with 5 with no duplicates or skips.
- Redirect to 9 while `if_pc` = 2 -> next cycle `if_valid` = 0; following cycle `if_pc` = 9.
- Redirect to 20 -> `fault` = 1, `halted` = 1, `if_valid` = 0; a later `start` clears `fault` and fetch restarts at 0.
- `rst_n` asserted mid-fetch at PC 7 -> all outputs at reset values immediately; `start` fetch resumes at 0.
- With `IFETCH_WRAP_EN`: after `if_pc` = 15 the next `if_pc` is 0; `halted` stays 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: fetch FSM states, instruction memory depth and word widths.
package mips_pkg;

  localparam int IMEM_DEPTH  = 16;
  localparam int INSTR_WIDTH = 32;
  localparam int ADDR_WIDTH  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/ifetch_out_reg.sv
// One-entry valid/ready output stage between instruction fetch and decode.
// Flush beats capture; acceptance without capture empties the stage.
module ifetch_out_reg
  import mips_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DATA_W = INSTR_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic              flush,
  input  logic              ready,
  input  logic [DATA_W-1:0] instr,
  input  logic [ADDR_W-1:0] pc,
  output logic              valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
);

  logic              valid_reg;
  logic [DATA_W-1:0] instr_reg;
  logic [ADDR_W-1:0] pc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      instr_reg <= '0;
      pc_reg    <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (capture) begin
      valid_reg <= 1'b1;
      instr_reg <= instr;
      pc_reg    <= pc;
    end else if (ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid     = valid_reg;
  assign out_instr = instr_reg;
  assign out_pc    = pc_reg;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives instruction memory, feeds decode.
// IFETCH_WRAP_EN: when defined, PC wraps to 0 after DEPTH-1 instead of draining to HALT.
module instr_fetch_ctrl
  import mips_pkg::*;
#(
  parameter int          ADDR_W   = ADDR_WIDTH,
  parameter int          DATA_W   = INSTR_WIDTH,
  parameter int          DEPTH    = IMEM_DEPTH,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [DATA_W-1:0] instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              busy,
  output logic              halted,
  output logic              fault
);

  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              fault_reg, fault_next;
  logic              capture, flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      pc_reg    <= START_PC;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      fault_reg <= fault_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    fault_next = fault_reg;
    capture    = 1'b0;
    flush      = 1'b0;
    case (state_reg)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_next = ST_FETCH;
          pc_next    = START_PC;
          fault_next = 1'b0;
        end
      end
      ST_FETCH, ST_DRAIN: begin
        if (redirect_valid) begin
          // Redirect outranks capture and the end-of-program transition.
          flush = 1'b1;
          if (redirect_pc < DEPTH_A) begin
            state_next = ST_FETCH;
            pc_next    = redirect_pc;
          end else begin
            state_next = ST_HALT;
            fault_next = 1'b1;
          end
        end else if (state_reg == ST_FETCH) begin
          if (!if_valid || if_ready) begin
            capture = 1'b1;
            if (pc_reg == LAST_PC) begin
`ifdef IFETCH_WRAP_EN
              pc_next = '0;
`else
              state_next = ST_DRAIN;
`endif
            end else begin
              pc_next = pc_reg + ADDR_W'(1);
            end
          end
        end else if (if_valid && if_ready) begin
          state_next = ST_HALT;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  ifetch_out_reg #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (capture),
    .flush    (flush),
    .ready    (if_ready),
    .instr    (instr),
    .pc       (pc_reg),
    .valid    (if_valid),
    .out_instr(if_instr),
    .out_pc   (if_pc)
  );

  assign instr_addr = pc_reg;
  assign busy       = (state_reg == ST_FETCH) || (state_reg == ST_DRAIN);
  assign halted     = (state_reg == ST_HALT);
  assign fault      = fault_reg;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed self-checking bench for instr_fetch_ctrl with a combinational memory model.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] instr_addr;
  logic [31:0] instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        busy, halted, fault;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [16];

  always #5 clk = ~clk;

  assign instr = (instr_addr < 32'd16) ? mem[instr_addr[3:0]] : 32'h0;

  instr_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr_addr(instr_addr), .instr(instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .busy(busy), .halted(halted), .fault(fault)
  );

  function automatic logic [31:0] word(input int i);
    return 32'hC0DE_0000 + 32'(i * 17);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, release, pulse start; returns 1 ns after the edge that accepted start.
  task automatic reset_and_start();
    redirect_valid = 1'b0;
    if_ready = 1'b1;
    start = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    checks++;
    if (if_valid !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 || fault !== 1'b0 ||
        instr_addr !== 32'd0 || if_instr !== 32'd0 || if_pc !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b halted=%b fault=%b addr=%0d instr=%h pc=%0d, want all zero",
               if_valid, busy, halted, fault, instr_addr, if_instr, if_pc);
    end
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (busy !== 1'b0 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_without_start: busy=%b valid=%b want 0 0", busy, if_valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_sweep();
    reset_and_start();
    checks++;
    if (busy !== 1'b1 || instr_addr !== 32'd0 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_latency: busy=%b addr=%0d valid=%b want 1 0 0", busy, instr_addr, if_valid);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'(i) || if_instr !== word(i)) begin
        errors++;
        $display("FAIL sweep_word: valid=%b pc=%0d instr=%h want 1 %0d %h", if_valid, if_pc, if_instr, i, word(i));
      end
      $display("sweep pc=%0d instr=%h", if_pc, if_instr);
    end
`ifdef IFETCH_WRAP_EN
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'd0 || if_instr !== word(0) || halted !== 1'b0) begin
      errors++;
      $display("FAIL wrap: valid=%b pc=%0d instr=%h halted=%b want 1 0 %h 0", if_valid, if_pc, if_instr, halted, word(0));
    end
`else
    checks++;
    if (busy !== 1'b1 || halted !== 1'b0 || instr_addr !== 32'd15) begin
      errors++;
      $display("FAIL drain_state: busy=%b halted=%b addr=%0d want 1 0 15", busy, halted, instr_addr);
    end
    step();
    checks++;
    if (halted !== 1'b1 || busy !== 1'b0 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_after_drain: halted=%b busy=%b valid=%b want 1 0 0", halted, busy, if_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'd3;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (halted !== 1'b1 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_in_halt: halted=%b valid=%b want 1 0", halted, if_valid);
    end
`endif
  endtask

  task automatic test_stall();
    reset_and_start();
    for (int i = 0; i < 5; i++) step();
    if_ready = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      start = 1'b0;
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'd4 || if_instr !== word(4) || instr_addr !== 32'd5) begin
        errors++;
        $display("FAIL stall_hold: valid=%b pc=%0d instr=%h addr=%0d want 1 4 %h 5", if_valid, if_pc, if_instr, instr_addr, word(4));
      end
      $display("stall cycle %0d pc=%0d addr=%0d", c, if_pc, instr_addr);
    end
    if_ready = 1'b1;
    for (int k = 5; k < 7; k++) begin
      step();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'(k) || if_instr !== word(k)) begin
        errors++;
        $display("FAIL stall_resume: valid=%b pc=%0d instr=%h want 1 %0d %h", if_valid, if_pc, if_instr, k, word(k));
      end
    end
  endtask

  task automatic test_redirect();
    reset_and_start();
    for (int i = 0; i < 3; i++) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'd9;
    if_ready = 1'b0;
    step();
    redirect_valid = 1'b0;
    if_ready = 1'b1;
    checks++;
    if (if_valid !== 1'b0 || instr_addr !== 32'd9) begin
      errors++;
      $display("FAIL redirect_flush: valid=%b addr=%0d want 0 9", if_valid, instr_addr);
    end
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'd9 || if_instr !== word(9)) begin
      errors++;
      $display("FAIL redirect_target: valid=%b pc=%0d instr=%h want 1 9 %h", if_valid, if_pc, if_instr, word(9));
    end
    $display("redirect pc=%0d instr=%h", if_pc, if_instr);
  endtask

  task automatic test_fault();
    reset_and_start();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'd20;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (fault !== 1'b1 || halted !== 1'b1 || if_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL redirect_fault: fault=%b halted=%b valid=%b busy=%b want 1 1 0 0", fault, halted, if_valid, busy);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (fault !== 1'b0 || busy !== 1'b1 || instr_addr !== 32'd0) begin
      errors++;
      $display("FAIL fault_clear: fault=%b busy=%b addr=%0d want 0 1 0", fault, busy, instr_addr);
    end
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'd0 || if_instr !== word(0)) begin
      errors++;
      $display("FAIL restart_after_fault: valid=%b pc=%0d instr=%h want 1 0 %h", if_valid, if_pc, if_instr, word(0));
    end
    $display("fault restart pc=%0d", if_pc);
  endtask

  task automatic test_async_reset();
    reset_and_start();
    for (int i = 0; i < 8; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (if_valid !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 || fault !== 1'b0 ||
        instr_addr !== 32'd0 || if_instr !== 32'd0 || if_pc !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%b busy=%b halted=%b fault=%b addr=%0d instr=%h pc=%0d want all zero",
               if_valid, busy, halted, fault, instr_addr, if_instr, if_pc);
    end
    step();
    rst_n = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'd0 || if_instr !== word(0)) begin
      errors++;
      $display("FAIL restart_after_reset: valid=%b pc=%0d instr=%h want 1 0 %h", if_valid, if_pc, if_instr, word(0));
    end
    $display("async reset restart pc=%0d", if_pc);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = word(i);
    #3;
    test_reset();
    test_sweep();
    test_stall();
    test_redirect();
    test_fault();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
